// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool with a half-row line buffer and an optional ReLU clamp.
// Accepts one raster-order pixel per valid cycle and emits one registered result per completed window.
module max_pool_2x2_stream #(
  parameter int W1   = 9,
  parameter int COLS = 24,
  parameter int ROWS = 24,
  localparam int HC_W = (COLS / 2 > 1) ? $clog2(COLS / 2) : 1,
  localparam int HR_W = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic                 in_valid,
  input  logic signed [W1-1:0] in_data,
  output logic                 out_valid,
  output logic signed [W1-1:0] out_data,
  output logic [HR_W-1:0]      out_row,
  output logic [HC_W-1:0]      out_col,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CC_W = $clog2(COLS);
  localparam int RC_W = $clog2(ROWS);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic signed [W1-1:0] smax(input logic signed [W1-1:0] a,
                                                input logic signed [W1-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic signed [W1-1:0] relu_clamp(input logic signed [W1-1:0] v,
                                                      input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [CC_W-1:0]       col_q, col_d;
  logic [RC_W-1:0]       row_q, row_d;
  logic signed [W1-1:0]  h_q;
  logic signed [W1-1:0]  row_buf [COLS/2];
  logic                  out_valid_q, frame_done_q;
  logic signed [W1-1:0]  out_data_q;
  logic [HR_W-1:0]       out_row_q;
  logic [HC_W-1:0]       out_col_q;

  logic                  accept, col_last, last_px, win_done;
  logic [HC_W-1:0]       col_h;
  logic signed [W1-1:0]  pair, win;

  // start overrides a coincident in_valid, so that pixel is never accepted
  assign accept   = (state_q == S_RUN) && in_valid && !start;
  assign col_last = (col_q == CC_W'(COLS - 1));
  assign last_px  = col_last && (row_q == RC_W'(ROWS - 1));
  assign win_done = accept && row_q[0] && col_q[0];
  assign col_h    = HC_W'(col_q >> 1);
  assign pair     = smax(h_q, in_data);
  assign win      = smax(row_buf[col_h], pair);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (start) begin
      state_d = S_RUN;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = last_px ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + CC_W'(1);
      end
      if (last_px) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= win_done;
      frame_done_q <= accept && last_px;
      if (accept && !col_q[0]) h_q <= in_data;
      if (win_done) begin
        out_data_q <= relu_clamp(win, relu_en);
        out_row_q  <= HR_W'(row_q >> 1);
        out_col_q  <= col_h;
      end
    end
  end

  // Line buffer carries even-row pair maxima; every entry is written before its odd-row read
  always_ff @(posedge clk) begin
    if (accept && !row_q[0] && col_q[0]) row_buf[col_h] <= pair;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = frame_done_q;

endmodule

// File: doc/max_pool_2x2_stream.md
# max_pool_2x2_stream

Streaming 2x2, stride-2 signed max-pooling stage for the CNN digit-classification datapath. It sits between a convolution/activation stage and the next layer. It accepts one feature-map pixel per valid cycle in raster order and emits one pooled value per 2x2 window. A half-row line buffer lets it pool a full map without frame storage, and an optional ReLU clamp applies on the output.

## Interface
- W1, default 9: signed pixel width (two's complement), input and output.
- COLS, default 24: feature-map width in pixels; must be even and ≥2.
- ROWS, default 24: feature-map height in pixels; must be even and ≥2.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; clears position counters and begins a frame (aborts any frame in progress).
- relu_en  in  1  when 1, a negative pooled result is output as 0; sampled with each odd-row, odd-column pixel.
- in_valid  in  1  qualifies in_data; pixel accepted on every cycle in RUN with in_valid=1.
- in_data  in  W1  signed input pixel.
- out_valid  out  1  one-cycle strobe per pooled value.
- out_data  out  W1  signed pooled value, held until next out_valid.
- out_row  out  clog2(ROWS/2) (min 1)  pooled row index of out_data.
- out_col  out  clog2(COLS/2) (min 1)  pooled column index of out_data.
- busy  out  1  1 in RUN.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- States: IDLE, RUN. Reset → IDLE. IDLE --start--> RUN. RUN --last pixel accepted (row ROWS-1, col COLS-1)--> IDLE. RUN --start--> RUN with counters cleared (abort; no output for partial windows).
- In IDLE, in_valid/in_data are ignored; counters hold.
- Counters col (0..COLS-1) and row (0..ROWS-1) advance only on accepted pixels; col wraps to 0 and increments row.
- Even col: pixel latched into h_reg.
- Odd col: pair = signed max(h_reg, in_data).
  - Even row: row_buf[col>>1] ← pair (COLS/2 entries x W1; contents not reset, always written before read).
  - Odd row: win = signed max(row_buf[col>>1], pair); out_data ← (relu_en && win<0) ? 0 : win; out_row ← row>>1; out_col ← col>>1; out_valid ← 1.
- All comparisons signed over full W1; no width growth, no saturation. Ties yield the equal value.
- Output count per complete frame: (COLS/2)*(ROWS/2), 144 at defaults.
- start and in_valid in the same cycle: start wins; that pixel is not accepted.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, frame_done=0, state=IDLE, counters=0, h_reg=0.
- Latency: out_valid asserts on the clock edge after the accepting edge of the odd-row, odd-col pixel (1 cycle registered).
- No backpressure: downstream must accept every out_valid. in_valid gaps of any length stall counters and pipeline without loss.
- Throughput: 1 pixel/cycle sustained; max one output per 4 input pixels in a row pair.
- busy deasserts on the same edge that registers the final output. frame_done and the final out_valid are high in the same cycle, while busy=0.
- Reset asserted mid-frame: all outputs and state return to reset values immediately. A pending out_valid is dropped; a new start is needed.
- Back-to-back frames: start may be pulsed in the cycle frame_done is high.

## Test plan
- COLS=4, ROWS=4, ramp 0..15 raster, relu_en=0 → out_valid 4 times: (0,0)=5, (0,1)=7, (1,0)=13, (1,1)=15; frame_done with the 4th.
- Window {-3,-7,-1,-9}: relu_en=0 → -1; relu_en=1 → 0. Window {-256,-256,-256,-256} (W1=9) → -256 / 0.
- Extremes: window {255,-256,0,254} → 255. Ties {4,4,4,4} → 4.
- Random in_valid gaps (30% idle) on the ramp frame → identical values and indices to the gap-free run, each 1 cycle after its completing pixel.
- start pulsed after 6 pixels, then a full ramp → exactly 4 outputs matching the first scenario; no output from the aborted data.
- rst_n low for 1 cycle mid-frame → out_valid=0, busy=0 immediately. Pixels without start produce no output; after start, a full frame is correct.
